// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared control-bundle layout, ALU op codes and pipeline constants
package pipeline_pkg;
  localparam int CTRL_W = 12;
  localparam int CTRL_REG_WRITE = 11;
  localparam int CTRL_MEM_READ = 10;
  localparam int CTRL_MEM_WRITE = 9;
  localparam int CTRL_MEM_TO_REG = 8;
  localparam int CTRL_ALU_SRC = 7;
  localparam int CTRL_REG_DST = 6;
  localparam int CTRL_LINK = 5;
  localparam int CTRL_ALU_OP = 0;
  typedef enum logic [4:0] {
    ALU_ADD = 5'd0,
    ALU_SUB = 5'd1,
    ALU_AND = 5'd2,
    ALU_OR  = 5'd3,
    ALU_XOR = 5'd4,
    ALU_NOR = 5'd5,
    ALU_SLT = 5'd6,
    ALU_SLL = 5'd7,
    ALU_SRL = 5'd8,
    ALU_SRA = 5'd9,
    ALU_LUI = 5'd10
  } alu_op_t;
  typedef struct packed {
    logic    regWrite;
    logic    memRead;
    logic    memWrite;
    logic    memToReg;
    logic    aluSrc;
    logic    regDst;
    logic    link;
    alu_op_t aluOp;
  } ctrl_t;
  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: combinational load-use stall (load in EX writing a register the ID instruction reads)
module hazard_detect import pipeline_pkg::*; #(
  parameter int ADDR_W = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [ADDR_W-1:0] ex_dest,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  output logic              stall
);
  assign stall = ex_valid & ex_mem_read & (ex_dest != ADDR_W'(REG_ZERO)) &
                 ((id_uses_rs & (id_rs == ex_dest)) | (id_uses_rt & (id_rt == ex_dest)));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble, freeze and flush; ID_EX_STALL_STATS_EN adds stallCount/flushCount
module id_ex_stage import pipeline_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              freeze,
  input  logic              flush,
  input  logic [ADDR_W-1:0] idRs,
  input  logic [ADDR_W-1:0] idRt,
  input  logic [ADDR_W-1:0] idRd,
  input  logic              idUsesRs,
  input  logic              idUsesRt,
  input  logic [DATA_W-1:0] readData1,
  input  logic [DATA_W-1:0] readData2,
  input  logic [DATA_W-1:0] idImm,
  input  logic [DATA_W-1:0] idPcPlus4,
  input  logic [CTRL_W-1:0] idCtrl,
  output logic              exValid,
  output logic [ADDR_W-1:0] exRs,
  output logic [ADDR_W-1:0] exRt,
  output logic [ADDR_W-1:0] exDest,
  output logic [DATA_W-1:0] exData1,
  output logic [DATA_W-1:0] exData2,
  output logic [DATA_W-1:0] exImm,
  output logic [DATA_W-1:0] exPcPlus4,
  output logic [CTRL_W-1:0] exCtrl,
  output logic              stall
`ifdef ID_EX_STALL_STATS_EN
  , output logic [31:0]     stallCount
  , output logic [31:0]     flushCount
`endif
);
  hazard_detect #(.ADDR_W(ADDR_W)) u_hazard (
    .ex_valid(exValid),
    .ex_mem_read(exCtrl[CTRL_MEM_READ]),
    .ex_dest(exDest),
    .id_rs(idRs),
    .id_rt(idRt),
    .id_uses_rs(idUsesRs),
    .id_uses_rt(idUsesRt),
    .stall(stall)
  );
  logic bubble;
  assign bubble = flush | stall;
  always_ff @(posedge clk) begin
    if (reset || (!freeze && bubble)) begin
      exValid   <= 1'b0;
      exRs      <= '0;
      exRt      <= '0;
      exDest    <= '0;
      exData1   <= '0;
      exData2   <= '0;
      exImm     <= '0;
      exPcPlus4 <= '0;
      exCtrl    <= BUBBLE_CTRL;
    end else if (!freeze) begin
      exValid   <= 1'b1;
      exRs      <= idRs;
      exRt      <= idRt;
      exDest    <= idCtrl[CTRL_REG_DST] ? idRd : idRt;
      exData1   <= readData1;
      exData2   <= readData2;
      exImm     <= idImm;
      exPcPlus4 <= idPcPlus4;
      exCtrl    <= idCtrl;
    end
  end
`ifdef ID_EX_STALL_STATS_EN
  // a flush that coincides with a stall is attributed to the flush only
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCount <= '0;
      flushCount <= '0;
    end else if (!freeze) begin
      stallCount <= stallCount + {31'd0, stall & ~flush};
      flushCount <= flushCount + {31'd0, flush};
    end
  end
`endif
endmodule
